// File: rtl/mux5_scan_ctrl.sv
// mux5_scan_ctrl: round-robin scheduler for a 5:1 sample mux.
// Grants one requesting source at a time, waits SETTLE_CYCLES for the mux output to
// settle, captures it with its channel tag and presents it on a valid/ready port.
// Optional build macro MUX5_CH_MASK_EN adds a ch_mask input that qualifies req.
module mux5_scan_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned DATA_W        = 12
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic [4:0]        req,
`ifdef MUX5_CH_MASK_EN
    input  logic [4:0]        ch_mask,
`endif
    output logic [4:0]        ack,
    output logic [2:0]        sel,
    input  logic [DATA_W-1:0] mux_data,
    output logic [DATA_W-1:0] out_data,
    output logic [2:0]        out_ch,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy
);

    localparam int unsigned CntW = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
    localparam logic [CntW-1:0] SettleInit = CntW'(SETTLE_CYCLES);

    typedef enum logic [1:0] {
        StIdle,
        StSettle,
        StHold
    } state_e;

    state_e            state_q, state_d;
    logic [2:0]        sel_q, sel_d;
    logic [2:0]        last_q, last_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [2:0]        ch_q, ch_d;
    logic              valid_q, valid_d;
    logic [4:0]        ack_q, ack_d;

    logic [4:0]        eff_req;
    logic [2:0]        grant;
    logic              grant_vld;
    logic [2:0]        cand;

`ifdef MUX5_CH_MASK_EN
    assign eff_req = req & ch_mask;
`else
    assign eff_req = req;
`endif

    // Round-robin search: first eligible request after the last served channel.
    always_comb begin
        grant     = 3'd0;
        grant_vld = 1'b0;
        cand      = last_q;
        for (int k = 0; k < 5; k++) begin
            cand = (cand == 3'd4) ? 3'd0 : cand + 3'd1;
            if (!grant_vld && eff_req[cand]) begin
                grant_vld = 1'b1;
                grant     = cand;
            end
        end
    end

    // Next-state and datapath updates for the grant/settle/hold sequence.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        ch_d    = ch_q;
        valid_d = valid_q;
        ack_d   = 5'b00000;
        case (state_q)
            StIdle: begin
                if (enable && grant_vld) begin
                    sel_d   = grant;
                    cnt_d   = SettleInit;
                    state_d = StSettle;
                end
            end
            StSettle: begin
                if (cnt_q == '0) begin
                    // Once granted, the sample is committed even if req has dropped.
                    data_d  = mux_data;
                    ch_d    = sel_q;
                    valid_d = 1'b1;
                    ack_d   = 5'b00001 << sel_q;
                    last_d  = sel_q;
                    state_d = StHold;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StHold: begin
                if (valid_q && out_ready) begin
                    valid_d = 1'b0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and output registers; last starts at 4 so channel 0 wins first.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            sel_q   <= 3'd0;
            last_q  <= 3'd4;
            cnt_q   <= '0;
            data_q  <= '0;
            ch_q    <= 3'd0;
            valid_q <= 1'b0;
            ack_q   <= 5'b00000;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            ch_q    <= ch_d;
            valid_q <= valid_d;
            ack_q   <= ack_d;
        end
    end

    assign sel       = sel_q;
    assign ack       = ack_q;
    assign out_data  = data_q;
    assign out_ch    = ch_q;
    assign out_valid = valid_q;
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_mux5_scan_ctrl.sv
// Directed bench for mux5_scan_ctrl (SETTLE_CYCLES=2 main instance, SETTLE_CYCLES=0 second).
// Define MUX5_CH_MASK_EN to also exercise the channel mask.
module tb_mux5_scan_ctrl;

    localparam int unsigned SETTLE = 2;
    localparam int unsigned DW     = 12;

    logic          clk       = 1'b0;
    logic          reset_n   = 1'b0;
    logic          enable    = 1'b0;
    logic          out_ready = 1'b0;
    logic [4:0]    req       = 5'b00000;
    logic [4:0]    req0      = 5'b00000;
    logic [4:0]    ch_mask   = 5'b11111;
    logic [DW-1:0] mux_data  = '0;

    logic [4:0]    ack, ack0;
    logic [2:0]    sel, sel0, out_ch, out_ch0;
    logic [DW-1:0] out_data, out_data0;
    logic          out_valid, out_valid0, busy, busy0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mux5_scan_ctrl #(.SETTLE_CYCLES(SETTLE), .DATA_W(DW)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .enable    (enable),
        .req       (req),
`ifdef MUX5_CH_MASK_EN
        .ch_mask   (ch_mask),
`endif
        .ack       (ack),
        .sel       (sel),
        .mux_data  (mux_data),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    mux5_scan_ctrl #(.SETTLE_CYCLES(0), .DATA_W(DW)) dut0 (
        .clk       (clk),
        .reset_n   (reset_n),
        .enable    (enable),
        .req       (req0),
`ifdef MUX5_CH_MASK_EN
        .ch_mask   (ch_mask),
`endif
        .ack       (ack0),
        .sel       (sel0),
        .mux_data  (mux_data),
        .out_data  (out_data0),
        .out_ch    (out_ch0),
        .out_valid (out_valid0),
        .out_ready (out_ready),
        .busy      (busy0)
    );

    task automatic do_reset();
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Bounded wait for an ack pulse on the main instance.
    task automatic wait_capture(output bit got);
        got = 1'b0;
        for (int t = 0; t < 40 && !got; t++) begin
            @(negedge clk);
            if (ack !== 5'b00000) got = 1'b1;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; enable = 1'b1; out_ready = 1'b1; req = '0; req0 = '0;
        repeat (2) @(negedge clk);
        checks++;
        if (sel !== 3'd0 || ack !== 5'd0 || busy !== 1'b0)
            begin errors++; $display("FAIL reset_ctrl sel=%0d ack=%b busy=%b want 0", sel, ack, busy); end
        checks++;
        if (out_data !== '0 || out_ch !== 3'd0 || out_valid !== 1'b0)
            begin errors++; $display("FAIL reset_out data=%h ch=%0d valid=%b want 0", out_data, out_ch, out_valid); end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        do_reset();
        mux_data = 12'h3A5; out_ready = 1'b1; req = 5'b00100;
        @(negedge clk);
        req = 5'b00000;
        checks++;
        if (sel !== 3'd2 || busy !== 1'b1)
            begin errors++; $display("FAIL single_grant sel=%0d busy=%b want 2/1", sel, busy); end
        repeat (SETTLE) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0 || ack !== 5'd0)
                begin errors++; $display("FAIL single_early valid=%b ack=%b want 0/0", out_valid, ack); end
        end
        @(negedge clk);
        checks++;
        if (ack !== 5'b00100 || out_valid !== 1'b1)
            begin errors++; $display("FAIL single_capture ack=%b valid=%b want 00100/1", ack, out_valid); end
        checks++;
        if (out_data !== 12'h3A5 || out_ch !== 3'd2)
            begin errors++; $display("FAIL single_data data=%h ch=%0d want 3a5/2", out_data, out_ch); end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || ack !== 5'd0)
            begin errors++; $display("FAIL single_done valid=%b busy=%b ack=%b want 0", out_valid, busy, ack); end
    endtask

    task automatic test_fairness();
        int cyc, prev, exp_ch;
        bit got;
        do_reset();
        out_ready = 1'b1; req = 5'b11111;
        cyc = 0; prev = 0;
        for (int n = 0; n < 6; n++) begin
            got = 1'b0;
            for (int t = 0; t < 30 && !got; t++) begin
                @(negedge clk); cyc++;
                if (ack !== 5'd0) got = 1'b1;
            end
            checks++;
            if (!got) begin
                errors++; $display("FAIL fair_timeout capture %0d never seen", n);
            end else begin
                exp_ch = n % 5;
                checks++;
                if (out_ch !== exp_ch[2:0] || ack !== (5'b00001 << exp_ch))
                    begin errors++; $display("FAIL fair_order ch=%0d ack=%b want %0d", out_ch, ack, exp_ch); end
                if (n > 0) begin
                    checks++;
                    if (cyc - prev != int'(SETTLE) + 3)
                        begin errors++; $display("FAIL fair_spacing got %0d want %0d", cyc - prev, SETTLE + 3); end
                end
                prev = cyc;
                @(negedge clk); cyc++;
                checks++;
                if (ack !== 5'd0)
                    begin errors++; $display("FAIL fair_pulse ack=%b want 00000", ack); end
            end
        end
        req = 5'b00000;
    endtask

    task automatic test_backpressure();
        bit got;
        do_reset();
        out_ready = 1'b0; mux_data = 12'h111; req = 5'b00010;
        wait_capture(got);
        checks++;
        if (!got) begin errors++; $display("FAIL bp_timeout no capture, want capture"); end
        req = 5'b11111;
        for (int i = 0; i < 10; i++) begin
            mux_data = 12'(32'h200 + i);
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_data !== 12'h111 || out_ch !== 3'd1 ||
                sel !== 3'd1 || busy !== 1'b1 || ack !== 5'd0)
                begin errors++; $display("FAIL bp_hold valid=%b data=%h ch=%0d sel=%0d busy=%b ack=%b want 1/111/1/1/1/0",
                    out_valid, out_data, out_ch, sel, busy, ack); end
        end
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0)
            begin errors++; $display("FAIL bp_release valid=%b busy=%b want 0/0", out_valid, busy); end
        @(negedge clk);
        checks++;
        if (sel !== 3'd2 || busy !== 1'b1)
            begin errors++; $display("FAIL bp_next sel=%0d busy=%b want 2/1", sel, busy); end
        req = 5'b00000;
    endtask

    task automatic test_wrap();
        bit got;
        do_reset();
        out_ready = 1'b1; req = 5'b01000;
        wait_capture(got);
        checks++;
        if (!got || out_ch !== 3'd3)
            begin errors++; $display("FAIL wrap_first got=%b ch=%0d want 1/3", got, out_ch); end
        req = 5'b00011;
        wait_capture(got);
        checks++;
        if (!got || out_ch !== 3'd0)
            begin errors++; $display("FAIL wrap_zero got=%b ch=%0d want 1/0", got, out_ch); end
        wait_capture(got);
        checks++;
        if (!got || out_ch !== 3'd1)
            begin errors++; $display("FAIL wrap_one got=%b ch=%0d want 1/1", got, out_ch); end
        req = 5'b00000;
    endtask

    task automatic test_enable();
        bit got;
        do_reset();
        enable = 1'b0; out_ready = 1'b1; req = 5'b00001;
        repeat (4) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b0 || ack !== 5'd0)
                begin errors++; $display("FAIL en_gate busy=%b ack=%b want 0/0", busy, ack); end
        end
        enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        checks++;
        if (busy !== 1'b1 || sel !== 3'd0)
            begin errors++; $display("FAIL en_grant busy=%b sel=%0d want 1/0", busy, sel); end
        wait_capture(got);
        checks++;
        if (!got || out_ch !== 3'd0)
            begin errors++; $display("FAIL en_finish got=%b ch=%0d want 1/0", got, out_ch); end
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b0)
                begin errors++; $display("FAIL en_nogrant busy=%b want 0", busy); end
        end
        enable = 1'b1; req = 5'b00000;
    endtask

    task automatic test_reset_mid();
        bit got;
        do_reset();
        out_ready = 1'b0; mux_data = 12'hABC; req = 5'b00100;
        wait_capture(got);
        out_ready = 1'b1; req = 5'b00010;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (sel !== 3'd1 || busy !== 1'b1 || out_data !== 12'hABC)
            begin errors++; $display("FAIL rmid_setup sel=%0d busy=%b data=%h want 1/1/abc", sel, busy, out_data); end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (sel !== 3'd0 || busy !== 1'b0 || out_valid !== 1'b0 || ack !== 5'd0 ||
            out_data !== '0 || out_ch !== 3'd0)
            begin errors++; $display("FAIL rmid_async sel=%0d busy=%b valid=%b ack=%b data=%h ch=%0d want 0",
                sel, busy, out_valid, ack, out_data, out_ch); end
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (ack !== 5'd0 || out_valid !== 1'b0)
                begin errors++; $display("FAIL rmid_held ack=%b valid=%b want 0/0", ack, out_valid); end
        end
        reset_n = 1'b1; req = 5'b00001; mux_data = 12'h5A5;
        wait_capture(got);
        checks++;
        if (!got || out_ch !== 3'd0 || out_data !== 12'h5A5)
            begin errors++; $display("FAIL rmid_after got=%b ch=%0d data=%h want 1/0/5a5", got, out_ch, out_data); end
        req = 5'b00000;
    endtask

    task automatic test_settle0();
        do_reset();
        out_ready = 1'b1; mux_data = 12'h7E1; req0 = 5'b00100;
        @(negedge clk);
        req0 = 5'b00000;
        checks++;
        if (sel0 !== 3'd2 || busy0 !== 1'b1 || ack0 !== 5'd0 || out_valid0 !== 1'b0)
            begin errors++; $display("FAIL s0_grant sel=%0d busy=%b ack=%b valid=%b want 2/1/0/0",
                sel0, busy0, ack0, out_valid0); end
        @(negedge clk);
        checks++;
        if (ack0 !== 5'b00100 || out_valid0 !== 1'b1 || out_data0 !== 12'h7E1 || out_ch0 !== 3'd2)
            begin errors++; $display("FAIL s0_capture ack=%b valid=%b data=%h ch=%0d want 00100/1/7e1/2",
                ack0, out_valid0, out_data0, out_ch0); end
        @(negedge clk);
        checks++;
        if (out_valid0 !== 1'b0 || busy0 !== 1'b0)
            begin errors++; $display("FAIL s0_done valid=%b busy=%b want 0/0", out_valid0, busy0); end
    endtask

`ifdef MUX5_CH_MASK_EN
    task automatic test_mask();
        bit got;
        logic [2:0] exp_seq [4];
        exp_seq[0] = 3'd0; exp_seq[1] = 3'd2; exp_seq[2] = 3'd4; exp_seq[3] = 3'd0;
        do_reset();
        out_ready = 1'b1; ch_mask = 5'b10101; req = 5'b11111;
        for (int n = 0; n < 4; n++) begin
            wait_capture(got);
            checks++;
            if (!got || out_ch !== exp_seq[n])
                begin errors++; $display("FAIL mask_order got=%b ch=%0d want %0d", got, out_ch, exp_seq[n]); end
        end
        req = 5'b00000; ch_mask = 5'b11111;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_backpressure();
        test_wrap();
        test_enable();
        test_reset_mid();
        test_settle0();
`ifdef MUX5_CH_MASK_EN
        test_mask();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
